// File: rtl/gpu_instruction_dispatcher.sv
// Instruction front-end for the sprite video processor: pops 64-bit host
// instructions and issues register writes, sprite-memory writes and fills.
module gpu_instruction_dispatcher #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 14,
  parameter int MEM_DATA_W = 9,
  parameter int REG_IDX_W  = 5,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rdreq,
  input  logic [DATA_W-1:0]     data_a,
  input  logic [DATA_W-1:0]     data_b,
  input  logic                  printing,
  output logic                  reg_wr,
  output logic [REG_IDX_W-1:0]  reg_idx,
  output logic [DATA_W-1:0]     reg_data,
  input  logic                  reg_done,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [MEM_DATA_W-1:0] mem_data,
  input  logic                  mem_done,
  output logic                  mem_sel,
  output logic                  busy,
  output logic                  err_opcode,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      inst_count,
  output logic [2:0]            state_dbg
);

  localparam int N_W   = DATA_W - 4 - ADDR_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_WBR  = 4'd0;
  localparam logic [3:0] OP_WSM  = 4'd1;
  localparam logic [3:0] OP_FILL = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT      = 3'd4,
    S_FILL_NEXT = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [3:0]            op_q;
  logic [REG_IDX_W-1:0]  reg_idx_q;
  logic [DATA_W-1:0]     reg_data_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [MEM_DATA_W-1:0] mem_data_q;
  logic [N_W-1:0]        remaining_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  mem_sel_q;
  logic                  err_opcode_q;
  logic                  err_timeout_q;
  logic [CNT_W-1:0]      inst_count_q;

  logic                  rdreq;
  logic                  strobe;

  // Decode straight from the FIFO word; only meaningful in LATCH.
  logic [3:0]     dec_op;
  logic [N_W-1:0] dec_n;
  logic           dec_illegal;
  logic           dec_fill_empty;

  assign dec_op         = data_a[3:0];
  assign dec_n          = data_a[DATA_W-1 -: N_W];
  assign dec_illegal    = (dec_op > OP_FILL);
  assign dec_fill_empty = (dec_op == OP_FILL) && (dec_n == '0);

  // Write handshake: a one-cycle strobe (reg_wr/mem_wr) launches the write and
  // the matching done is accepted only in WAIT, i.e. from the cycle after the
  // strobe; any other done is ignored.
  logic op_is_fill;
  logic last_word;
  logic done_in;
  logic inst_done;
  logic timeout_hit;

  assign op_is_fill  = (op_q == OP_FILL);
  assign last_word   = (remaining_q == N_W'(1));
  assign done_in     = (op_q == OP_WBR) ? reg_done : mem_done;
  assign inst_done   = ((state == S_LATCH) && dec_fill_empty) ||
                       ((state == S_WAIT) && done_in && (!op_is_fill || last_word));
  assign timeout_hit = (state == S_WAIT) && !done_in && (tmo_q == TMO_W'(1));

  always_comb begin
    state_next = state;
    rdreq      = 1'b0;
    strobe     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !printing) begin
          rdreq      = 1'b1;
          state_next = S_POP;
        end
      end
      S_POP:   state_next = S_LATCH;
      S_LATCH: state_next = (dec_illegal || dec_fill_empty) ? S_IDLE : S_ISSUE;
      S_ISSUE: begin
        if (!printing) begin
          strobe     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_in) begin
          state_next = (op_is_fill && !last_word) ? S_FILL_NEXT : S_IDLE;
        end else if (tmo_q == TMO_W'(1)) begin
          state_next = S_IDLE;
        end
      end
      S_FILL_NEXT: state_next = S_ISSUE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      op_q          <= '0;
      reg_idx_q     <= '0;
      reg_data_q    <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      remaining_q   <= '0;
      tmo_q         <= '0;
      mem_sel_q     <= 1'b0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      inst_count_q  <= '0;
    end else begin
      state <= state_next;
      if (inst_done)   inst_count_q  <= inst_count_q + CNT_W'(1);
      if (timeout_hit) err_timeout_q <= 1'b1;
      case (state)
        S_LATCH: begin
          op_q        <= dec_op;
          reg_idx_q   <= data_a[4 +: REG_IDX_W];
          reg_data_q  <= data_b;
          mem_addr_q  <= data_a[4 +: ADDR_W];
          mem_data_q  <= data_b[MEM_DATA_W-1:0];
          remaining_q <= dec_n;
          if (dec_illegal) err_opcode_q <= 1'b1;
          mem_sel_q   <= (state_next == S_ISSUE) && (dec_op != OP_WBR);
        end
        S_ISSUE: begin
          // Timeout counts down to 1, so the error lands TIMEOUT cycles after the strobe.
          if (strobe) tmo_q <= TMO_W'(TIMEOUT - 1);
        end
        S_WAIT: begin
          if (done_in) begin
            if (op_is_fill) remaining_q <= remaining_q - N_W'(1);
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        S_FILL_NEXT: mem_addr_q <= mem_addr_q + ADDR_W'(1);
        default: ;
      endcase
      if (state_next == S_IDLE) mem_sel_q <= 1'b0;
    end
  end

  // Combinational outputs are masked so nothing escapes in the first reset cycle.
  assign fifo_rdreq  = rdreq && !reset;
  assign reg_wr      = strobe && (op_q == OP_WBR) && !reset;
  assign mem_wr      = strobe && (op_q != OP_WBR) && !reset;
  assign busy        = (state != S_IDLE) && !reset;
  assign state_dbg   = reset ? 3'd0 : state;
  assign reg_idx     = reg_idx_q;
  assign reg_data    = reg_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_sel     = mem_sel_q;
  assign err_opcode  = err_opcode_q;
  assign err_timeout = err_timeout_q;
  assign inst_count  = inst_count_q;

endmodule
